// File: rtl/cbu_cntr_pkg.sv
// Shared constants and elaboration-time helpers for the cascadable up/down modulo counter family.
// Optional build macro honoured by users of this package: CBU_SATURATE_EN (saturate instead of wrap).
package cbu_cntr_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Terminal value for a direction: last state before a wrap.
  function automatic longint unsigned term_val(input logic dir, input longint unsigned modulus);
    return (dir == DIR_DN) ? 64'd0 : modulus - 64'd1;
  endfunction

  function automatic longint unsigned clamp_load(input longint unsigned d, input longint unsigned modulus);
    return (d > modulus - 64'd1) ? modulus - 64'd1 : d;
  endfunction

  function automatic bit params_legal(input int width, input longint unsigned modulus,
                                      input longint unsigned rst_val);
    if (width < 1 || width > 32) return 1'b0;
    if (modulus < 64'd2 || modulus > (64'd1 << width)) return 1'b0;
    return rst_val < modulus;
  endfunction

endpackage

// File: rtl/cbu_cntr_next.sv
// Combinational next-count and wrap detection for one counter stage.
// Build macro CBU_SATURATE_EN: a would-be wrap holds the current value instead of wrapping.
module cbu_cntr_next
  import cbu_cntr_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic [WIDTH-1:0] Q,
  input  logic             DIR,
  input  logic             CAI,
  output logic [WIDTH-1:0] q_next,
  output logic             wrap
);

  localparam logic [WIDTH:0] LAST_EXT = (WIDTH+1)'(MODULUS - 64'd1);

  logic [WIDTH:0]   up_ext;
  logic [WIDTH:0]   dn_ext;
  logic             past_last;
  logic             below_zero;
  logic [WIDTH-1:0] wrap_up_val;
  logic [WIDTH-1:0] wrap_dn_val;

`ifdef CBU_SATURATE_EN
  assign wrap_up_val = Q;
  assign wrap_dn_val = Q;
`else
  assign wrap_up_val = '0;
  assign wrap_dn_val = LAST_EXT[WIDTH-1:0];
`endif

  // One extra bit keeps MODULUS == 2^WIDTH exact without relying on natural rollover.
  always_comb begin
    up_ext     = {1'b0, Q} + (WIDTH+1)'(1);
    dn_ext     = {1'b0, Q} - (WIDTH+1)'(1);
    past_last  = (up_ext > LAST_EXT);
    below_zero = dn_ext[WIDTH];
    wrap       = CAI && ((DIR == DIR_UP) ? past_last : below_zero);
    q_next     = Q;
    if (CAI) begin
      if (DIR == DIR_UP) begin
        q_next = past_last ? wrap_up_val : up_ext[WIDTH-1:0];
      end else begin
        q_next = below_zero ? wrap_dn_val : dn_ext[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/cbu_updn_mod_counter.sv
// Parametrised cascadable up/down modulo counter with load, sticky wrap flag and terminal count.
// Build macro CBU_SATURATE_EN selects saturating instead of wrapping behaviour.
module cbu_updn_mod_counter
  import cbu_cntr_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 16,
  parameter longint unsigned RST_VAL = 0
) (
  input  logic             CLK,
  input  logic             CDN,
  input  logic             CAI,
  input  logic             DIR,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             CLR_OVF,
  output logic [WIDTH-1:0] Q,
  output logic             CAO,
  output logic             TC,
  output logic             OVF
);

  if (!params_legal(WIDTH, MODULUS, RST_VAL)) begin : g_param_check
    $error("cbu_updn_mod_counter: illegal WIDTH/MODULUS/RST_VAL combination");
  end

  localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(term_val(DIR_UP, MODULUS));
  localparam logic [WIDTH-1:0] TERM_DN = WIDTH'(term_val(DIR_DN, MODULUS));
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] term_now;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] load_val;
  logic             wrap;

  assign term_now = (DIR == DIR_UP) ? TERM_UP : TERM_DN;
  assign load_val = WIDTH'(clamp_load(64'(D), MODULUS));

  cbu_cntr_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .Q      (q_q),
    .DIR    (DIR),
    .CAI    (CAI),
    .q_next (q_step),
    .wrap   (wrap)
  );

  // A load swallows the count, so it also suppresses the wrap event.
  always_comb begin
    q_d   = LD ? load_val : q_step;
    tc_d  = (q_q == term_now);
    ovf_d = ovf_q;
    if (wrap && !LD) begin
      ovf_d = 1'b1;
    end else if (CLR_OVF) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!CDN) begin
      q_q   <= RST_Q;
      ovf_q <= 1'b0;
      tc_q  <= (RST_Q == term_now);
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
      tc_q  <= tc_d;
    end
  end

  assign Q   = q_q;
  assign CAO = wrap;
  assign TC  = tc_q;
  assign OVF = ovf_q;

endmodule

// File: tb/tb_cbu_updn_mod_counter.sv
// Directed self-checking bench for cbu_updn_mod_counter (MODULUS=10 units plus a two-stage MODULUS=16 cascade).
// Expectations follow CBU_SATURATE_EN when the bench is built with that macro.
module tb_cbu_updn_mod_counter;

`ifdef CBU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       cdn, cai, dir, ld, clr_ovf;
  logic [3:0] d;
  logic [3:0] q, q5;
  logic       cao, tc, ovf, cao5, tc5, ovf5;
  logic       cai0;
  logic [3:0] q0, q1;
  logic       cao0, cao1, tc0, tc1, ovf0, ovf1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  cbu_updn_mod_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) u_dut (
    .CLK(clk), .CDN(cdn), .CAI(cai), .DIR(dir), .LD(ld), .D(d), .CLR_OVF(clr_ovf),
    .Q(q), .CAO(cao), .TC(tc), .OVF(ovf));

  cbu_updn_mod_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(5)) u_rst5 (
    .CLK(clk), .CDN(cdn), .CAI(cai), .DIR(dir), .LD(ld), .D(d), .CLR_OVF(clr_ovf),
    .Q(q5), .CAO(cao5), .TC(tc5), .OVF(ovf5));

  cbu_updn_mod_counter #(.WIDTH(4), .MODULUS(16), .RST_VAL(0)) u_c0 (
    .CLK(clk), .CDN(cdn), .CAI(cai0), .DIR(1'b1), .LD(1'b0), .D(4'd0), .CLR_OVF(1'b0),
    .Q(q0), .CAO(cao0), .TC(tc0), .OVF(ovf0));

  cbu_updn_mod_counter #(.WIDTH(4), .MODULUS(16), .RST_VAL(0)) u_c1 (
    .CLK(clk), .CDN(cdn), .CAI(cao0), .DIR(1'b1), .LD(1'b0), .D(4'd0), .CLR_OVF(1'b0),
    .Q(q1), .CAO(cao1), .TC(tc1), .OVF(ovf1));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cdn = 1'b0; cai = 1'b0; dir = 1'b1; ld = 1'b0; d = 4'd0; clr_ovf = 1'b0; cai0 = 1'b0;
    tick;
    cdn = 1'b1;
    tick;
    checks++; if (q !== 4'd0)  begin errors++; $display("FAIL reset_q got %0d want 0", q); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", ovf); end
    checks++; if (tc !== 1'b0)  begin errors++; $display("FAIL reset_tc got %0b want 0", tc); end
    checks++; if (cao !== 1'b0) begin errors++; $display("FAIL reset_cao got %0b want 0", cao); end
    checks++; if (q5 !== 4'd5)  begin errors++; $display("FAIL reset_q_rst5 got %0d want 5", q5); end
    checks++; if ({q1, q0} !== 8'h00) begin errors++; $display("FAIL reset_cascade got %h want 00", {q1, q0}); end
    $display("test_reset done q=%0d ovf=%0b tc=%0b", q, ovf, tc);
  endtask

  task automatic test_count_up;
    logic [3:0] exp_q;
    dir = 1'b1; ld = 1'b0; clr_ovf = 1'b0; cai = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (q !== 4'(i)) begin errors++; $display("FAIL up_q[%0d] got %0d want %0d", i, q, i); end
      checks++; if (cao !== (i == 9)) begin errors++; $display("FAIL up_cao[%0d] got %0b want %0b", i, cao, (i == 9)); end
      checks++; if (tc !== 1'b0) begin errors++; $display("FAIL up_tc[%0d] got %0b want 0", i, tc); end
      tick;
    end
    exp_q = SAT ? 4'd9 : 4'd0;
    checks++; if (q !== exp_q)  begin errors++; $display("FAIL up_wrap_q got %0d want %0d", q, exp_q); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL up_wrap_ovf got %0b want 1", ovf); end
    checks++; if (tc !== 1'b1)  begin errors++; $display("FAIL up_wrap_tc got %0b want 1", tc); end
    cai = 1'b0;
    tick;
    checks++; if (tc !== SAT) begin errors++; $display("FAIL up_tc_after got %0b want %0b", tc, SAT); end
    $display("test_count_up done q=%0d ovf=%0b", q, ovf);
  endtask

  task automatic test_count_down;
    int exp_cur[5], exp_nxt[5], exp_cao[5], exp_tc[5];
    int exp_ovf[5] = '{0, 0, 0, 1, 1};
    if (SAT) begin
      exp_cur = '{3, 2, 1, 0, 0}; exp_nxt = '{2, 1, 0, 0, 0};
      exp_cao = '{0, 0, 0, 1, 1}; exp_tc  = '{0, 0, 0, 1, 1};
    end else begin
      exp_cur = '{3, 2, 1, 0, 9}; exp_nxt = '{2, 1, 0, 9, 8};
      exp_cao = '{0, 0, 0, 1, 0}; exp_tc  = '{0, 0, 0, 1, 0};
    end
    dir = 1'b0; ld = 1'b1; d = 4'd3; clr_ovf = 1'b1; cai = 1'b0;
    tick;
    ld = 1'b0; clr_ovf = 1'b0;
    checks++; if (q !== 4'd3)   begin errors++; $display("FAIL dn_load_q got %0d want 3", q); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL dn_load_clr_ovf got %0b want 0", ovf); end
    cai = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (q !== 4'(exp_cur[k])) begin errors++; $display("FAIL dn_cur[%0d] got %0d want %0d", k, q, exp_cur[k]); end
      checks++; if (cao !== 1'(exp_cao[k])) begin errors++; $display("FAIL dn_cao[%0d] got %0b want %0d", k, cao, exp_cao[k]); end
      tick;
      checks++; if (q !== 4'(exp_nxt[k])) begin errors++; $display("FAIL dn_q[%0d] got %0d want %0d", k, q, exp_nxt[k]); end
      checks++; if (ovf !== 1'(exp_ovf[k])) begin errors++; $display("FAIL dn_ovf[%0d] got %0b want %0d", k, ovf, exp_ovf[k]); end
      checks++; if (tc !== 1'(exp_tc[k])) begin errors++; $display("FAIL dn_tc[%0d] got %0b want %0d", k, tc, exp_tc[k]); end
    end
    cai = 1'b0;
    $display("test_count_down done q=%0d ovf=%0b", q, ovf);
  endtask

  task automatic test_load_clamp;
    dir = 1'b1; ld = 1'b1; d = 4'd15; clr_ovf = 1'b1; cai = 1'b0;
    tick;
    clr_ovf = 1'b0;
    checks++; if (q !== 4'd9)   begin errors++; $display("FAIL ld_clamp_q got %0d want 9", q); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ld_clamp_ovf got %0b want 0", ovf); end
    d = 4'd4; cai = 1'b1;
    #1;
    checks++; if (cao !== 1'b1) begin errors++; $display("FAIL ld_cao_ungated got %0b want 1", cao); end
    tick;
    checks++; if (q !== 4'd4)   begin errors++; $display("FAIL ld_over_cai_q got %0d want 4", q); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ld_no_wrap_ovf got %0b want 0", ovf); end
    d = 4'd10;
    tick;
    checks++; if (q !== 4'd9)   begin errors++; $display("FAIL ld_clamp10_q got %0d want 9", q); end
    ld = 1'b0; cai = 1'b0;
    $display("test_load_clamp done q=%0d", q);
  endtask

  task automatic test_clr_ovf;
    logic [3:0] exp_q;
    exp_q = SAT ? 4'd9 : 4'd0;
    dir = 1'b1; ld = 1'b0; cai = 1'b1; clr_ovf = 1'b0;
    tick;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL clr_pre_ovf got %0b want 1", ovf); end
    ld = 1'b1; d = 4'd9; cai = 1'b0;
    tick;
    ld = 1'b0; cai = 1'b1; clr_ovf = 1'b1;
    tick;
    checks++; if (q !== exp_q)  begin errors++; $display("FAIL clr_wrap_q got %0d want %0d", q, exp_q); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL clr_set_wins got %0b want 1", ovf); end
    cai = 1'b0;
    tick;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_alone got %0b want 0", ovf); end
    clr_ovf = 1'b0;
    $display("test_clr_ovf done ovf=%0b", ovf);
  endtask

  task automatic test_reset_mid;
    dir = 1'b1; ld = 1'b1; d = 4'd9; cai = 1'b0; clr_ovf = 1'b0;
    tick;
    ld = 1'b0; cai = 1'b1;
    tick;
    cai = 1'b0; ld = 1'b1; d = 4'd7;
    tick;
    checks++; if (q !== 4'd7)   begin errors++; $display("FAIL rmid_pre_q got %0d want 7", q); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL rmid_pre_ovf got %0b want 1", ovf); end
    cdn = 1'b0; cai = 1'b1; ld = 1'b1; d = 4'd2;
    tick;
    checks++; if (q !== 4'd0)    begin errors++; $display("FAIL rmid_q got %0d want 0", q); end
    checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL rmid_ovf got %0b want 0", ovf); end
    checks++; if (q5 !== 4'd5)   begin errors++; $display("FAIL rmid_q5 got %0d want 5", q5); end
    checks++; if (ovf5 !== 1'b0) begin errors++; $display("FAIL rmid_ovf5 got %0b want 0", ovf5); end
    cdn = 1'b1; ld = 1'b0;
    #1;
    checks++; if (cao5 !== 1'b0) begin errors++; $display("FAIL rmid_cao5 got %0b want 0", cao5); end
    tick;
    checks++; if (q5 !== 4'd6) begin errors++; $display("FAIL rmid_q5_next got %0d want 6", q5); end
    checks++; if (q !== 4'd1)  begin errors++; $display("FAIL rmid_q_next got %0d want 1", q); end
    tick;
    checks++; if (q5 !== 4'd7) begin errors++; $display("FAIL rmid_q5_next2 got %0d want 7", q5); end
    checks++; if (tc5 !== 1'b0) begin errors++; $display("FAIL rmid_tc5 got %0b want 0", tc5); end
    cai = 1'b0;
    $display("test_reset_mid done q=%0d q5=%0d", q, q5);
  endtask

  task automatic test_dir_change;
    dir = 1'b0; cai = 1'b1;
    tick;
    checks++; if (q !== 4'd1) begin errors++; $display("FAIL dirchg_q got %0d want 1", q); end
    cai = 1'b0; ld = 1'b1; d = 4'd0; dir = 1'b1;
    tick;
    ld = 1'b0;
    tick;
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL dirchg_tc_up got %0b want 0", tc); end
    dir = 1'b0;
    #1;
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL dirchg_tc_lag got %0b want 0", tc); end
    tick;
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL dirchg_tc_dn got %0b want 1", tc); end
    cai = 1'b1;
    #1;
    checks++; if (cao !== 1'b1) begin errors++; $display("FAIL dirchg_cao got %0b want 1", cao); end
    cai = 1'b0;
    $display("test_dir_change done q=%0d tc=%0b", q, tc);
  endtask

  task automatic test_cascade;
    int lo, hi;
    cai0 = 1'b1;
    #1;
    for (int k = 1; k <= 256; k++) begin
      lo = SAT ? ((k - 1) < 15 ? (k - 1) : 15) : (k - 1) % 16;
      checks++; if (cao0 !== (lo == 15)) begin errors++; $display("FAIL casc_cao0[%0d] got %0b want %0b", k, cao0, (lo == 15)); end
      if (k == 256) begin
        checks++; if (cao1 !== 1'b1) begin errors++; $display("FAIL casc_cao1 got %0b want 1", cao1); end
      end
      tick;
      if (SAT) begin
        lo = (k < 15) ? k : 15;
        hi = (k <= 15) ? 0 : ((k - 15) < 15 ? (k - 15) : 15);
      end else begin
        lo = k % 16;
        hi = (k / 16) % 16;
      end
      checks++;
      if (q0 !== 4'(lo) || q1 !== 4'(hi)) begin
        errors++; $display("FAIL casc_q[%0d] got %h want %h", k, {q1, q0}, {4'(hi), 4'(lo)});
      end
    end
    cai0 = 1'b0;
    checks++; if (ovf1 !== 1'b1) begin errors++; $display("FAIL casc_ovf1 got %0b want 1", ovf1); end
    checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL casc_ovf0 got %0b want 1", ovf0); end
    checks++; if (tc0 !== 1'b1)  begin errors++; $display("FAIL casc_tc0 got %0b want 1", tc0); end
    checks++; if (tc1 !== 1'b1)  begin errors++; $display("FAIL casc_tc1 got %0b want 1", tc1); end
    $display("test_cascade done q=%h ovf1=%0b", {q1, q0}, ovf1);
  endtask

  initial begin
    test_reset;
    test_count_up;
    test_count_down;
    test_load_clamp;
    test_clr_ovf;
    test_reset_mid;
    test_dir_change;
    test_cascade;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
